// File: rtl/uart_tx_feeder_pkg.sv
// Shared types and defaults for the MIDI-port UART transmit feeder.
// Launch-sequencer state encodings live here so both RTL and tools agree.
package uart_tx_feeder_pkg;

    localparam int DEPTH_LOG2_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_STROBE    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_feeder_byte_fifo.sv
// Circular byte queue with extra-MSB pointers for full/empty detection.
// Overflow is a registered one-cycle pulse on a push into a full queue.
module byte_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] ONE = 1;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // full is judged before any same-cycle pop, so push-into-full always drops
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full;
            if (do_push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue plus launch sequencer feeding one UART transmitter.
// One byte per frame; data is presented a clock before the strobe.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  tx_strobe,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy
);

    state_t     state;
    logic       pop;
    logic [7:0] head;

    assign pop = (state == ST_IDLE) && !empty && !tx_busy;

    byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .push_data(wr_data),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tx_strobe <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data <= head;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_strobe <= 1'b1;
                    state     <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (clk_en) begin
                        tx_strobe <= 1'b0;
                        state     <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    // a missed busy still consumes the byte; never resend
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (clk_en) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx_strobe <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural transmitter model.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       hold_busy = 1'b0;
    logic       mbusy = 1'b0;
    logic       tx_busy;
    logic       full, empty, overflow, tx_strobe;
    logic [4:0] level;
    logic [7:0] tx_data;

    logic       wr_en2 = 1'b0;
    logic [7:0] wr_data2 = 8'h00;
    logic       busy2 = 1'b1;
    logic       full2, empty2, ovf2, stb2;
    logic [2:0] level2;
    logic [7:0] data2;

    int n_cmp = 0;
    int n_err = 0;
    int viol = 0;
    int ovf_cnt = 0;
    int stb_cnt = 0;
    int busy_ticks = 10;
    int ticks = 0;
    int div = 0;
    bit stb_prev = 1'b0;
    logic [7:0] rx_q [$];

    assign tx_busy = mbusy | hold_busy;

    always #5 clk = ~clk;

    uart_tx_feeder dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level),
        .overflow(overflow), .tx_strobe(tx_strobe),
        .tx_data(tx_data), .tx_busy(tx_busy)
    );

    uart_tx_feeder #(.DEPTH_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .wr_en(wr_en2), .wr_data(wr_data2),
        .full(full2), .empty(empty2), .level(level2),
        .overflow(ovf2), .tx_strobe(stb2),
        .tx_data(data2), .tx_busy(busy2)
    );

    // Transmitter model: samples strobe on clk_en edges, busy for busy_ticks ticks.
    always @(posedge clk) begin
        logic en_s, stb_s, busy_s, ovf_s;
        logic [7:0] dat_s;
        en_s = clk_en;
        stb_s = tx_strobe;
        busy_s = tx_busy;
        ovf_s = overflow;
        dat_s = tx_data;
        #1;
        if (stb_s && busy_s) viol++;
        if (ovf_s) ovf_cnt++;
        if (stb_s && !stb_prev) stb_cnt++;
        stb_prev = stb_s;
        if (en_s && stb_s && !busy_s) begin
            rx_q.push_back(dat_s);
            mbusy = 1'b1;
            ticks = 0;
        end else if (mbusy && en_s) begin
            ticks++;
            if (ticks >= busy_ticks) mbusy = 1'b0;
        end
        clk_en = (div == 14);
        div = (div + 1) % 16;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        wr_en2 = 1'b1;
        wr_data2 = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({level, empty, tx_strobe, tx_data} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
                n_err++;
                $display("FAIL reset_hold: level=%0d empty=%b stb=%b data=%h req 0/1/0/00",
                         level, empty, tx_strobe, tx_data);
            end
            n_cmp++;
            if ({level2, empty2, full2, ovf2} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_hold2: level=%0d empty=%b full=%b ovf=%b req 0/1/0/0",
                         level2, empty2, full2, ovf2);
            end
        end
        wr_en = 1'b0;
        wr_en2 = 1'b0;
        rst = 1'b1;
        step(3);
        n_cmp++;
        if ({empty, level, stb_cnt} !== {1'b1, 5'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_nowrite: empty=%b level=%0d strobes=%0d req 1/0/0",
                     empty, level, stb_cnt);
        end
    endtask

    task automatic test_single_byte();
        int base;
        int k;
        logic en_at;
        busy_ticks = 10;
        rx_q.delete();
        base = stb_cnt;
        wr_data = 8'h90;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        n_cmp++;
        if (level !== 5'd1 || tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL single_push: level=%0d data=%h req 1/00", level, tx_data);
        end
        step();
        n_cmp++;
        if (tx_data !== 8'h90 || tx_strobe !== 1'b0 || level !== 5'd0) begin
            n_err++;
            $display("FAIL single_data: data=%h stb=%b level=%0d req 90/0/0",
                     tx_data, tx_strobe, level);
        end
        step();
        n_cmp++;
        if (tx_strobe !== 1'b1) begin
            n_err++;
            $display("FAIL single_strobe_rise: stb=%b req 1", tx_strobe);
        end
        k = 0;
        en_at = 1'b0;
        do begin
            en_at = clk_en;
            step();
            k++;
        end while (tx_strobe && k < 40);
        n_cmp++;
        if (tx_strobe !== 1'b0 || en_at !== 1'b1) begin
            n_err++;
            $display("FAIL single_strobe_fall: stb=%b en_at_edge=%b req 0/1",
                     tx_strobe, en_at);
        end
        k = 0;
        while (!tx_busy && k < 40) begin step(); k++; end
        while (tx_busy && k < 400) begin step(); k++; end
        n_cmp++;
        if (k >= 400) begin
            n_err++;
            $display("FAIL single_busy_timeout: waited=%0d req <400", k);
        end
        step(40);
        n_cmp++;
        if (stb_cnt !== base + 1 || level !== 5'd0 || rx_q.size() != 1) begin
            n_err++;
            $display("FAIL single_once: strobes=%0d level=%0d rx=%0d req %0d/0/1",
                     stb_cnt - base, level, rx_q.size(), 1);
        end else begin
            n_cmp++;
            if (rx_q[0] !== 8'h90) begin
                n_err++;
                $display("FAIL single_rx: got=%h req 90", rx_q[0]);
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp [3];
        int base;
        int k;
        exp = '{8'h90, 8'h3C, 8'h7F};
        busy_ticks = 3;
        rx_q.delete();
        base = stb_cnt;
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = exp[i];
            wr_en = 1'b1;
            step();
        end
        wr_en = 1'b0;
        n_cmp++;
        if (level !== 5'd3) begin
            n_err++;
            $display("FAIL burst_level: level=%0d req 3", level);
        end
        hold_busy = 1'b0;
        k = 0;
        while (rx_q.size() < 3 && k < 800) begin step(); k++; end
        step(2);
        n_cmp++;
        if (rx_q.size() != 3 || stb_cnt !== base + 3) begin
            n_err++;
            $display("FAIL burst_count: rx=%0d strobes=%0d req 3/3",
                     rx_q.size(), stb_cnt - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rx_q[i] !== exp[i]) begin
                    n_err++;
                    $display("FAIL burst_order[%0d]: got=%h req %h", i, rx_q[i], exp[i]);
                end
            end
        end
        n_cmp++;
        if (viol != 0) begin
            n_err++;
            $display("FAIL burst_strobe_while_busy: count=%0d req 0", viol);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [5];
        logic [7:0] got [$];
        int k;
        int extra;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        busy2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data2 = exp[i];
            wr_en2 = 1'b1;
            step();
        end
        n_cmp++;
        if (full2 !== 1'b1 || level2 !== 3'd4 || ovf2 !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_full: full=%b level=%0d ovf=%b req 1/4/0", full2, level2, ovf2);
        end
        wr_data2 = exp[4];
        step();
        wr_en2 = 1'b0;
        n_cmp++;
        if (ovf2 !== 1'b1 || level2 !== 3'd4) begin
            n_err++;
            $display("FAIL ovf_pulse: ovf=%b level=%0d req 1/4", ovf2, level2);
        end
        step();
        n_cmp++;
        if (ovf2 !== 1'b0 || level2 !== 3'd4) begin
            n_err++;
            $display("FAIL ovf_one_clk: ovf=%b level=%0d req 0/4", ovf2, level2);
        end
        busy2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (!stb2 && k < 60) begin step(); k++; end
            got.push_back(data2);
            while (stb2 && k < 100) begin step(); k++; end
            busy2 = 1'b1;
            step(3);
            busy2 = 1'b0;
        end
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (stb2) extra++;
        end
        n_cmp++;
        if (extra != 0 || level2 !== 3'd0 || empty2 !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drain: extra_strobe_clks=%0d level=%0d empty=%b req 0/0/1",
                     extra, level2, empty2);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL ovf_order[%0d]: got=%h req %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int base;
        int k;
        busy_ticks = 1;
        rx_q.delete();
        base = ovf_cnt;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            while (full && k < 4000) begin
                wr_en = 1'b0;
                step();
                k++;
            end
            wr_data = 8'(i);
            wr_en = 1'b1;
            step();
        end
        wr_en = 1'b0;
        k = 0;
        while (rx_q.size() < 40 && k < 4000) begin step(); k++; end
        step(2);
        n_cmp++;
        if (rx_q.size() != 40 || ovf_cnt != base) begin
            n_err++;
            $display("FAIL wrap_count: rx=%0d overflows=%0d req 40/0",
                     rx_q.size(), ovf_cnt - base);
        end
        for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== 8'(i)) begin
                n_err++;
                $display("FAIL wrap_order[%0d]: got=%h req %h", i, rx_q[i], 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int k;
        logic [7:0] bytes [4];
        bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        busy_ticks = 3;
        step(20);
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = bytes[i];
            wr_en = 1'b1;
            step();
        end
        wr_en = 1'b0;
        hold_busy = 1'b0;
        k = 0;
        while (!tx_strobe && k < 100) begin step(); k++; end
        n_cmp++;
        if (tx_strobe !== 1'b1 || level !== 5'd3) begin
            n_err++;
            $display("FAIL mid_setup: stb=%b level=%0d req 1/3", tx_strobe, level);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({tx_strobe, level, empty, tx_data} !== {1'b0, 5'd0, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL mid_reset: stb=%b level=%0d empty=%b data=%h req 0/0/1/00",
                     tx_strobe, level, empty, tx_data);
        end
        step(2);
        rst = 1'b1;
        base = stb_cnt;
        step(60);
        n_cmp++;
        if (stb_cnt != base || level !== 5'd0 || tx_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL mid_quiet: strobes=%0d level=%0d stb=%b req 0/0/0",
                     stb_cnt - base, level, tx_strobe);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
